// File: rtl/cmos_nand_pkg.sv
// Shared constants for the cmos_nand cell: default counter width and the
// all-ones reset value of the registered output.
package cmos_nand_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;
    localparam int unsigned MAX_WIDTH     = 64;

    // All-ones mask of the given width, the NAND of idle-low inputs.
    function automatic logic [MAX_WIDTH-1:0] y_reset(input int unsigned width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/cmos_nand_cell.sv
// Switch-level bit-slice used by cmos_nand: one 4-transistor CMOS NAND.
module nand2_cell (
    input  logic a,
    input  logic b,
    output logic y
);

    supply1 vdd;
    supply0 gnd;
    wire    y_sw;
    wire    mid;

    // Parallel pull-up: either low input drives the output high.
    pmos p_a (y_sw, vdd, a);
    pmos p_b (y_sw, vdd, b);

    // Series pull-down: both inputs high connect the output to ground.
    nmos n_a (y_sw, mid, a);
    nmos n_b (mid, gnd, b);

    assign y = y_sw;

endmodule

// File: rtl/cmos_nand.sv
// Bit-sliced switch-level NAND with a registered copy of the output and a
// saturating count of edges on which the registered copy changed.
module cmos_nand
    import cmos_nand_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic [CNT_W-1:0] toggles
);

    localparam logic [MAX_WIDTH-1:0] Y_RESET_FULL = y_reset(WIDTH);
    localparam logic [WIDTH-1:0]     Y_RESET      = Y_RESET_FULL[WIDTH-1:0];
    localparam logic [CNT_W-1:0]     CNT_MAX      = '1;

    logic [CNT_W-1:0] toggles_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        nand2_cell u_cell (
            .a (a[i]),
            .b (b[i]),
            .y (y[i])
        );
    end

    // An unknown y makes the inequality unknown, so the count holds.
    always_comb begin
        toggles_d = toggles;
        if ((y != y_q) && (toggles != CNT_MAX)) begin
            toggles_d = toggles + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q     <= Y_RESET;
            toggles <= '0;
        end else begin
            y_q     <= y;
            toggles <= toggles_d;
        end
    end

endmodule

// File: tb/tb_cmos_nand.sv
// Directed bench for cmos_nand: a 1-bit instance with the default counter and
// a 4-bit instance with a 2-bit counter for saturation.
module tb_cmos_nand;

    logic       clk;
    logic       rst;
    logic       clk_run;
    logic       a1, b1, y1, y_q1;
    logic [7:0] tog1;
    logic [3:0] a4, b4, y4, y_q4;
    logic [1:0] tog4;

    int checks;
    int errors;
    bit four_state;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
    } vec_t;

    vec_t vecs[5];

    cmos_nand #(.WIDTH(1), .CNT_W(8)) u_w1 (
        .clk     (clk),
        .rst     (rst),
        .a       (a1),
        .b       (b1),
        .y       (y1),
        .y_q     (y_q1),
        .toggles (tog1)
    );

    cmos_nand #(.WIDTH(4), .CNT_W(2)) u_w4 (
        .clk     (clk),
        .rst     (rst),
        .a       (a4),
        .b       (b4),
        .y       (y4),
        .y_q     (y_q4),
        .toggles (tog4)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic xprobe;
        logic [7:0] tog_before;
        logic [1:0] sat_exp[5];

        checks  = 0;
        errors  = 0;
        clk_run = 1'b0;
        rst     = 1'b1;
        a1 = 1'b0; b1 = 1'b0; a4 = '0; b4 = '0;
        xprobe = 1'bx;
        four_state = (xprobe === 1'bx);

        vecs[0] = '{a: 4'b0000, b: 4'b0000, y: 4'b1111};
        vecs[1] = '{a: 4'b0000, b: 4'b1111, y: 4'b1111};
        vecs[2] = '{a: 4'b1111, b: 4'b0000, y: 4'b1111};
        vecs[3] = '{a: 4'b1111, b: 4'b1111, y: 4'b0000};
        vecs[4] = '{a: 4'b1100, b: 4'b1010, y: 4'b0111};

        // Static truth table under reset, clock stopped.
        #10;
        for (int i = 0; i < 5; i++) begin
            a1 = vecs[i].a[0]; b1 = vecs[i].b[0];
            a4 = vecs[i].a;    b4 = vecs[i].b;
            #50;
            check($sformatf("static_y1[%0d]", i), {31'd0, y1}, {31'd0, vecs[i].y[0]});
            check($sformatf("static_y4[%0d]", i), {28'd0, y4}, {28'd0, vecs[i].y});
            check($sformatf("rst_yq1[%0d]", i), {31'd0, y_q1}, 32'd1);
            check($sformatf("rst_tog1[%0d]", i), {24'd0, tog1}, 32'd0);
            #50;
        end
        check("rst_yq4", {28'd0, y_q4}, 32'hF);

        if (four_state) begin
            a1 = 1'b0; b1 = 1'bx; #10;
            check("x_a0_bx", {31'd0, y1}, 32'd1);
            a1 = 1'bx; b1 = 1'b0; #10;
            check("x_ax_b0", {31'd0, y1}, 32'd1);
            a1 = 1'b1; b1 = 1'bx; #10;
            check("x_a1_bx", {31'd0, y1}, {31'd0, 1'bx});
            a1 = 1'b1; b1 = 1'bz; #10;
            check("x_a1_bz", {31'd0, y1}, {31'd0, 1'bx});
        end

        // Registered latency: release reset with idle inputs.
        a1 = 1'b0; b1 = 1'b0; a4 = '0; b4 = '0;
        clk_run = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        next_edge();
        check("lat_yq1_idle", {31'd0, y_q1}, 32'd1);
        check("lat_tog1_idle", {24'd0, tog1}, 32'd0);
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; a4 = 4'b1100; b4 = 4'b1010;
        #1;
        check("lat_y1_comb", {31'd0, y1}, 32'd0);
        check("lat_yq1_before", {31'd0, y_q1}, 32'd1);
        next_edge();
        check("lat_yq1", {31'd0, y_q1}, 32'd0);
        check("lat_tog1", {24'd0, tog1}, 32'd1);
        check("mb_yq4", {28'd0, y_q4}, 32'h7);
        check("mb_tog4", {30'd0, tog4}, 32'd1);
        next_edge();
        check("lat_tog1_hold", {24'd0, tog1}, 32'd1);

        // Asynchronous reset mid-cycle with a=b=1.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_yq1", {31'd0, y_q1}, 32'd1);
        check("arst_tog1", {24'd0, tog1}, 32'd0);
        check("arst_y1", {31'd0, y1}, 32'd0);
        check("arst_yq4", {28'd0, y_q4}, 32'hF);
        check("arst_tog4", {30'd0, tog4}, 32'd0);
        next_edge();
        check("arst_hold_edge", {31'd0, y_q1}, 32'd1);

        // Saturation on the 2-bit counter; u_w1 keeps y=0 meanwhile.
        a4 = '0; b4 = '0;
        @(negedge clk);
        rst = 1'b0;
        next_edge();
        check("post_rst_yq1", {31'd0, y_q1}, 32'd0);
        check("post_rst_tog1", {24'd0, tog1}, 32'd1);
        check("sat_start", {30'd0, tog4}, 32'd0);
        sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a4 = (i % 2 == 0) ? 4'hF : 4'h0;
            b4 = a4;
            next_edge();
            check($sformatf("sat_tog4[%0d]", i), {30'd0, tog4}, {30'd0, sat_exp[i]});
        end

        // A sampled X must not advance the counter.
        if (four_state) begin
            tog_before = tog1;
            @(negedge clk);
            a1 = 1'b1; b1 = 1'bx;
            next_edge();
            check("x_sample_yq1", {31'd0, y_q1}, {31'd0, 1'bx});
            check("x_sample_tog1", {24'd0, tog1}, {24'd0, tog_before});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, expected finish before 20000");
        $fatal(1);
    end

endmodule
